// File: rtl/evm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evm_pkg
// Description : Shared definitions for the vote tally and the winner
//               selector: poll FSM encoding, candidate count, tally widths
//               and the illegal ballot select code.
// Revision    : 1.0 - initial release
// ============================================================================
package evm_pkg;

    localparam int NUM_CAND = 3;
    localparam int CNT_W    = 4;
    localparam int SEL_W    = 2;
    localparam int TOTAL_W  = 6;

    localparam logic [CNT_W-1:0]   CNT_MAX     = 4'd15;
    localparam logic [TOTAL_W-1:0] TOTAL_MAX   = 6'd63;
    localparam logic [SEL_W-1:0]   SEL_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_ARMED  = 2'b10,
        ST_CLOSED = 2'b11
    } poll_state_e;

endpackage : evm_pkg
`default_nettype wire

// File: rtl/sat_counter_4bit.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter_4bit
// Description : One per-candidate tally. Counts up on inc, sticks at the
//               maximum value, clears synchronously on clr or rst.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_4bit
    import evm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already full.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 4'd1;
        end
    end

    // Tally register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == CNT_MAX);

endmodule : sat_counter_4bit
`default_nettype wire

// File: rtl/vote_tally.sv
`default_nettype none
// ============================================================================
// Module      : vote_tally
// Description : Poll controller and ballot tally. A voter authorization arms
//               exactly one ballot; legal ballots bump a saturating slot
//               counter and the saturating total, illegal selects are
//               rejected without consuming the authorization.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_tally
    import evm_pkg::*;
#(
    parameter logic [CNT_W-1:0] CAND_ID0 = 4'd1,
    parameter logic [CNT_W-1:0] CAND_ID1 = 4'd2,
    parameter logic [CNT_W-1:0] CAND_ID2 = 4'd3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             open_poll,
    input  logic                             close_poll,
    input  logic                             voter_auth,
    input  logic                             ballot_valid,
    input  logic [SEL_W-1:0]                 ballot_sel,
    output logic                             ballot_ready,
    output logic                             vote_ack,
    output logic                             vote_reject,
    output logic [NUM_CAND-1:0][CNT_W-1:0]   candidate_numbers,
    output logic [NUM_CAND-1:0][CNT_W-1:0]   vote_counts,
    output logic [TOTAL_W-1:0]               total_votes,
    output logic [1:0]                       poll_state,
    output logic                             results_valid,
    output logic                             sat_flag
);

    poll_state_e                     state_q, state_d;
    logic [TOTAL_W-1:0]              total_q, total_d;
    logic                            sat_q, sat_d;
    logic                            ack_q, ack_d;
    logic                            rej_q, rej_d;

    logic                            w_handshake;
    logic                            w_accept;
    logic                            w_reject;
    logic                            w_clear;
    logic [NUM_CAND-1:0]             w_inc;
    logic [NUM_CAND-1:0]             w_hit_max;
    logic [NUM_CAND-1:0]             w_at_max;
    logic [NUM_CAND-1:0][CNT_W-1:0]  w_count;

    // A ballot is only ever seen while armed; the select decides its fate.
    assign w_handshake = ballot_valid && (state_q == ST_ARMED);
    assign w_accept    = w_handshake && (ballot_sel != SEL_ILLEGAL);
    assign w_reject    = w_handshake && (ballot_sel == SEL_ILLEGAL);

    // Next-state logic; a fresh poll (from IDLE or CLOSED) clears the tallies.
    always_comb begin
        state_d = state_q;
        w_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (open_poll) begin
                    state_d = ST_OPEN;
                    w_clear = 1'b1;
                end
            end
            ST_OPEN: begin
                if (close_poll) begin
                    state_d = ST_CLOSED;
                end else if (voter_auth) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (close_poll) begin
                    state_d = ST_CLOSED;
                end else if (w_accept) begin
                    state_d = ST_OPEN;
                end
            end
            ST_CLOSED: begin
                if (open_poll) begin
                    state_d = ST_OPEN;
                    w_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One saturating counter per candidate slot.
    for (genvar i = 0; i < NUM_CAND; i++) begin : g_slot
        assign w_inc[i]     = w_accept && (ballot_sel == SEL_W'(i));
        // Flag saturation on the vote that lands on (or beyond) the maximum.
        assign w_hit_max[i] = w_inc[i] && (w_at_max[i] || (w_count[i] == (CNT_MAX - 4'd1)));

        sat_counter_4bit u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (w_clear),
            .inc    (w_inc[i]),
            .count  (w_count[i]),
            .at_max (w_at_max[i])
        );
    end

    // Total, sticky saturation flag and the one-cycle response pulses.
    always_comb begin
        total_d = total_q;
        sat_d   = sat_q | (|w_hit_max);
        ack_d   = w_accept;
        rej_d   = w_reject;
        if (w_clear) begin
            total_d = '0;
            sat_d   = 1'b0;
        end else if (w_accept && (total_q != TOTAL_MAX)) begin
            total_d = total_q + 6'd1;
        end
    end

    // Control and summary registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            sat_q   <= 1'b0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
        end
    end

    assign ballot_ready      = (state_q == ST_ARMED);
    assign results_valid     = (state_q == ST_CLOSED);
    assign poll_state        = state_q;
    assign vote_ack          = ack_q;
    assign vote_reject       = rej_q;
    assign vote_counts       = w_count;
    assign total_votes       = total_q;
    assign sat_flag          = sat_q;
    assign candidate_numbers = {CAND_ID2, CAND_ID1, CAND_ID0};

endmodule : vote_tally
`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_tally
// Description : Self-checking bench for vote_tally. Directed scenarios plus
//               random traffic against a behavioural poll model; ack/reject
//               expectations flow through a scoreboard queue to a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_tally;

    logic             clk = 1'b0;
    logic             rst;
    logic             open_poll, close_poll, voter_auth, ballot_valid;
    logic [1:0]       ballot_sel;
    logic             ballot_ready, vote_ack, vote_reject;
    logic [2:0][3:0]  candidate_numbers, vote_counts;
    logic [5:0]       total_votes;
    logic [1:0]       poll_state;
    logic             results_valid, sat_flag;

    vote_tally dut (
        .clk               (clk),
        .rst               (rst),
        .open_poll         (open_poll),
        .close_poll        (close_poll),
        .voter_auth        (voter_auth),
        .ballot_valid      (ballot_valid),
        .ballot_sel        (ballot_sel),
        .ballot_ready      (ballot_ready),
        .vote_ack          (vote_ack),
        .vote_reject       (vote_reject),
        .candidate_numbers (candidate_numbers),
        .vote_counts       (vote_counts),
        .total_votes       (total_votes),
        .poll_state        (poll_state),
        .results_valid     (results_valid),
        .sat_flag          (sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_ack    = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of the poll ----------------
    // States use the published codes: 0 idle, 1 open, 2 armed, 3 closed.
    int m_st;
    int m_cnt[3];
    int m_total;
    bit m_sat;

    typedef struct {
        int stamp;
        bit is_ack;
        int c0, c1, c2, tot;
        bit sat;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void m_clear();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_total = 0;
        m_sat   = 1'b0;
    endfunction

    function automatic void m_push(input bit is_ack);
        exp_t e;
        e.stamp  = cyc + 1;
        e.is_ack = is_ack;
        e.c0 = m_cnt[0]; e.c1 = m_cnt[1]; e.c2 = m_cnt[2];
        e.tot = m_total; e.sat = m_sat;
        sb.push_back(e);
    endfunction

    function automatic void m_step(input bit r, o, c, a, v, input int s);
        if (r) begin
            m_st = 0;
            m_clear();
            return;
        end
        case (m_st)
            0: if (o) begin m_clear(); m_st = 1; end
            1: if (c) m_st = 3; else if (a) m_st = 2;
            2: begin
                if (v && s < 3) begin
                    m_cnt[s] = min_i(m_cnt[s] + 1, 15);
                    m_total  = min_i(m_total + 1, 63);
                    if (m_cnt[s] == 15) m_sat = 1'b1;
                    m_push(1'b1);
                    m_st = c ? 3 : 1;
                end else begin
                    if (v) m_push(1'b0);
                    if (c) m_st = 3;
                end
            end
            default: if (o) begin m_clear(); m_st = 1; end
        endcase
    endfunction

    // One clock: drive at the falling edge, predict, then check the result.
    task automatic step(input bit r, o, c, a, v, input int s);
        rst = r; open_poll = o; close_poll = c; voter_auth = a;
        ballot_valid = v; ballot_sel = 2'(s);
        m_step(r, o, c, a, v, s);
        @(negedge clk);
        chk("poll_state",    poll_state,    m_st);
        chk("results_valid", results_valid, (m_st == 3));
        chk("ballot_ready",  ballot_ready,  (m_st == 2));
        chk("count0",        vote_counts[0], m_cnt[0]);
        chk("count1",        vote_counts[1], m_cnt[1]);
        chk("count2",        vote_counts[2], m_cnt[2]);
        chk("total_votes",   total_votes,   m_total);
        chk("sat_flag",      sat_flag,      m_sat);
    endtask

    task automatic vote(input int s);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, s);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].stamp < cyc) begin
                mon_e = sb.pop_front();
                chk("pulse_missing", {vote_ack, vote_reject}, mon_e.is_ack ? 2'b10 : 2'b01);
            end
            if (vote_ack || vote_reject) begin
                if (sb.size() > 0 && sb[0].stamp == cyc) begin
                    mon_e = sb.pop_front();
                    if (vote_ack) n_ack++;
                    chk("pulse_kind", {vote_ack, vote_reject}, mon_e.is_ack ? 2'b10 : 2'b01);
                    chk("pulse_count0", vote_counts[0], mon_e.c0);
                    chk("pulse_count1", vote_counts[1], mon_e.c1);
                    chk("pulse_count2", vote_counts[2], mon_e.c2);
                    chk("pulse_total",  total_votes,    mon_e.tot);
                    chk("pulse_sat",    sat_flag,       mon_e.sat);
                end else begin
                    chk("pulse_unexpected", {vote_ack, vote_reject}, 2'b00);
                end
            end else if (sb.size() > 0 && sb[0].stamp == cyc) begin
                mon_e = sb.pop_front();
                chk("pulse_missing", 2'b00, mon_e.is_ack ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int acks0;

    initial begin
        rst = 1'b1; open_poll = 0; close_poll = 0; voter_auth = 0;
        ballot_valid = 0; ballot_sel = 0;
        m_st = 0; m_clear();
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        chk("reset_state", poll_state, 0);
        chk("reset_ack", {vote_ack, vote_reject}, 0);
        chk("cand_numbers", candidate_numbers, 12'h321);

        // Three votes for slot 1.
        step(0, 1, 0, 0, 0, 0);
        acks0 = n_ack;
        for (int i = 0; i < 3; i++) vote(1);
        step(0, 0, 0, 0, 0, 0);
        chk("seq1_count1", vote_counts[1], 3);
        chk("seq1_total", total_votes, 3);
        chk("seq1_acks", n_ack - acks0, 3);
        chk("seq1_state", poll_state, 1);

        // Illegal select keeps the authorization, then a legal one counts.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 3);
        chk("reject_state", poll_state, 2);
        step(0, 0, 0, 0, 1, 0);
        chk("after_reject_count0", vote_counts[0], 1);

        // Saturation of slot 2 and of the total.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) vote(2);
        chk("sat_count2", vote_counts[2], 15);
        chk("sat_flag17", sat_flag, 1);
        chk("sat_total17", total_votes, 17);
        for (int i = 0; i < 50; i++) vote(i % 2);
        chk("total_sat63", total_votes, 63);

        // Close together with an accepted ballot, then reopen clears.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("reopen_total", total_votes, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("close_vote_count0", vote_counts[0], 1);
        chk("close_vote_rv", results_valid, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, i);

        // Stray ballots and stacked authorizations.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        chk("single_ballot_count1", vote_counts[1], 1);
        step(0, 0, 1, 1, 0, 0);
        chk("auth_close_state", poll_state, 3);

        // Reset mid-ballot, then reopen from CLOSED.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("midballot_rst_state", poll_state, 0);
        step(0, 1, 0, 0, 0, 0);
        vote(2);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("reopen_count2", vote_counts[2], 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 3));
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        chk("cand_numbers_end", candidate_numbers, 12'h321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vote_tally
`default_nettype wire
